// File: rtl/mem_channel_arbiter.sv
// Purpose : shares one memory channel (read + write side) among NUM_CONSUMERS
//           requesters with round-robin grant; a consumer's read wins over its own write.
// Latency : memory valid appears 1 cycle after the request is sampled; consumer
//           ready appears 1 cycle after the memory ready is sampled.
// Backpressure: a granted consumer keeps its ready until it drops its valid;
//           no new grant is issued until then, and the grant is never on that same edge.
//
// Ports:
//   clk, reset (synchronous, active low)
//   consumer_read_valid/address  -> consumer_read_ready/data   (per-consumer read)
//   consumer_write_valid/address/data -> consumer_write_ready  (per-consumer write)
//   mem_read_valid/address, mem_read_ready/data                (memory read side)
//   mem_write_valid/address/data, mem_write_ready              (memory write side)
//   grant_id (consumer being served), busy (not IDLE), timeout_error (1-cycle pulse)
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abandon a memory access after
// TIMEOUT_CYCLES wait cycles (read data returned as 0, timeout_error pulsed).
module mem_channel_arbiter #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
  output logic                                 busy,
  output logic                                 timeout_error
);

  localparam int GW = $clog2(NUM_CONSUMERS);

  if (NUM_CONSUMERS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_channel_arbiter: NUM_CONSUMERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_WRITE_WAIT,
    S_READ_RELAY,
    S_WRITE_RELAY
  } state_t;

  state_t                           r_state, w_state;
  logic [GW-1:0]                    r_last_grant, w_last_grant;
  logic [GW-1:0]                    r_grant_id, w_grant_id;
  logic                             r_mem_rd_vld, w_mem_rd_vld;
  logic [ADDR_BITS-1:0]             r_mem_rd_addr, w_mem_rd_addr;
  logic                             r_mem_wr_vld, w_mem_wr_vld;
  logic [ADDR_BITS-1:0]             r_mem_wr_addr, w_mem_wr_addr;
  logic [DATA_BITS-1:0]             r_mem_wr_dat, w_mem_wr_dat;
  logic [NUM_CONSUMERS-1:0]         r_rd_ready, w_rd_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_rd_data, w_rd_data;
  logic [NUM_CONSUMERS-1:0]         r_wr_ready, w_wr_ready;

  // Round-robin search results.
  logic                             w_found;
  logic [GW-1:0]                    w_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]                    r_tmo_cnt, w_tmo_cnt;
  logic                             r_timeout_error, w_timeout_error;
`endif

  always_comb begin
    w_state       = r_state;
    w_last_grant  = r_last_grant;
    w_grant_id    = r_grant_id;
    w_mem_rd_vld  = r_mem_rd_vld;
    w_mem_rd_addr = r_mem_rd_addr;
    w_mem_wr_vld  = r_mem_wr_vld;
    w_mem_wr_addr = r_mem_wr_addr;
    w_mem_wr_dat  = r_mem_wr_dat;
    w_rd_ready    = r_rd_ready;
    w_rd_data     = r_rd_data;
    w_wr_ready    = r_wr_ready;
    w_found       = 1'b0;
    w_idx         = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_tmo_cnt       = r_tmo_cnt;
    w_timeout_error = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        // Scan last_grant+1 .. last_grant+N so the last winner is checked last.
        for (int k = 1; k <= NUM_CONSUMERS; k++) begin
          if (!w_found) begin
            w_idx = GW'((int'(r_last_grant) + k) % NUM_CONSUMERS);
            if ((consumer_read_valid[w_idx]  && !r_rd_ready[w_idx]) ||
                (consumer_write_valid[w_idx] && !r_wr_ready[w_idx])) begin
              w_found = 1'b1;
            end
          end
        end
        if (w_found) begin
          w_last_grant = w_idx;
          w_grant_id   = w_idx;
          // A consumer's own read is served ahead of its write.
          if (consumer_read_valid[w_idx] && !r_rd_ready[w_idx]) begin
            w_mem_rd_vld  = 1'b1;
            w_mem_rd_addr = consumer_read_address[w_idx*ADDR_BITS +: ADDR_BITS];
            w_state       = S_READ_WAIT;
          end else begin
            w_mem_wr_vld  = 1'b1;
            w_mem_wr_addr = consumer_write_address[w_idx*ADDR_BITS +: ADDR_BITS];
            w_mem_wr_dat  = consumer_write_data[w_idx*DATA_BITS +: DATA_BITS];
            w_state       = S_WRITE_WAIT;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        w_tmo_cnt = '0;
`endif
      end

      S_READ_WAIT: begin
        if (mem_read_ready) begin
          w_mem_rd_vld = 1'b0;
          w_rd_data[r_grant_id*DATA_BITS +: DATA_BITS] = mem_read_data;
          w_rd_ready[r_grant_id] = 1'b1;
          w_state = S_READ_RELAY;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_mem_rd_vld    = 1'b0;
          w_rd_data[r_grant_id*DATA_BITS +: DATA_BITS] = '0;
          w_rd_ready[r_grant_id] = 1'b1;
          w_timeout_error = 1'b1;
          w_state         = S_READ_RELAY;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 1'b1;
        end
`endif
      end

      S_WRITE_WAIT: begin
        if (mem_write_ready) begin
          w_mem_wr_vld = 1'b0;
          w_wr_ready[r_grant_id] = 1'b1;
          w_state = S_WRITE_RELAY;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_mem_wr_vld    = 1'b0;
          w_wr_ready[r_grant_id] = 1'b1;
          w_timeout_error = 1'b1;
          w_state         = S_WRITE_RELAY;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 1'b1;
        end
`endif
      end

      S_READ_RELAY: begin
        if (!consumer_read_valid[r_grant_id]) begin
          w_rd_ready = '0;
          w_state    = S_IDLE;
        end
      end

      S_WRITE_RELAY: begin
        if (!consumer_write_valid[r_grant_id]) begin
          w_wr_ready = '0;
          w_state    = S_IDLE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GW'(NUM_CONSUMERS - 1);
      r_grant_id    <= '0;
      r_mem_rd_vld  <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_vld  <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_dat  <= '0;
      r_rd_ready    <= '0;
      r_rd_data     <= '0;
      r_wr_ready    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tmo_cnt       <= '0;
      r_timeout_error <= 1'b0;
`endif
    end else begin
      r_state       <= w_state;
      r_last_grant  <= w_last_grant;
      r_grant_id    <= w_grant_id;
      r_mem_rd_vld  <= w_mem_rd_vld;
      r_mem_rd_addr <= w_mem_rd_addr;
      r_mem_wr_vld  <= w_mem_wr_vld;
      r_mem_wr_addr <= w_mem_wr_addr;
      r_mem_wr_dat  <= w_mem_wr_dat;
      r_rd_ready    <= w_rd_ready;
      r_rd_data     <= w_rd_data;
      r_wr_ready    <= w_wr_ready;
`ifdef MEM_ARB_TIMEOUT_EN
      r_tmo_cnt       <= w_tmo_cnt;
      r_timeout_error <= w_timeout_error;
`endif
    end
  end

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_read_data   = r_rd_data;
  assign consumer_write_ready = r_wr_ready;
  assign mem_read_valid       = r_mem_rd_vld;
  assign mem_read_address     = r_mem_rd_addr;
  assign mem_write_valid      = r_mem_wr_vld;
  assign mem_write_address    = r_mem_wr_addr;
  assign mem_write_data       = r_mem_wr_dat;
  assign grant_id             = r_grant_id;
  assign busy                 = (r_state != S_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_error        = r_timeout_error;
`else
  assign timeout_error        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: each request's expected grant, address,
// data and returned read data are queued when driven and checked when served.
module tb_mem_channel_arbiter;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NC-1:0]    c_rv, c_wv, c_rr, c_wr;
  logic [NC*AB-1:0] c_ra, c_wa;
  logic [NC*DB-1:0] c_wd, c_rd;
  logic             m_rv, m_wv, m_rr, m_wr;
  logic [AB-1:0]    m_ra, m_wa;
  logic [DB-1:0]    m_rd, m_wd;
  logic [1:0]       gid;
  logic             busy, terr;

  mem_channel_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
    .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
    .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
    .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
    .mem_read_valid(m_rv), .mem_read_address(m_ra),
    .mem_read_ready(m_rr), .mem_read_data(m_rd),
    .mem_write_valid(m_wv), .mem_write_address(m_wa),
    .mem_write_data(m_wd), .mem_write_ready(m_wr),
    .grant_id(gid), .busy(busy), .timeout_error(terr)
  );

  typedef struct packed {
    logic       wr;
    logic [1:0] id;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [7:0] mem_model(input logic [7:0] a);
    return a ^ 8'hB2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_rd(input int id, input logic [7:0] a, input bit push);
    exp_t e;
    c_ra[id*AB +: AB] = a;
    c_rv[id] = 1'b1;
    if (push) begin
      e.wr = 1'b0; e.id = 2'(id); e.addr = a; e.data = mem_model(a);
      sb.push_back(e);
    end
  endtask

  task automatic req_wr(input int id, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    c_wa[id*AB +: AB] = a;
    c_wd[id*DB +: DB] = d;
    c_wv[id] = 1'b1;
    e.wr = 1'b1; e.id = 2'(id); e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Waits for the next memory request, checks it against the queue head,
  // holds the memory off for lat cycles, then completes it.
  task automatic serve(input string tag, input int lat, output int waited);
    exp_t e;
    int   n;
    n = 0;
    while (!(m_rv || m_wv) && n < 50) begin tick(); n++; end
    waited = n;
    chk({tag, " req_seen"}, 32'(m_rv | m_wv), 32'd1);
    if (!(m_rv || m_wv)) return;
    chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " grant_id"}, 32'(gid), 32'(e.id));
    chk({tag, " is_write"}, 32'(m_wv), 32'(e.wr));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (e.wr) begin
      chk({tag, " mem_wr_addr"}, 32'(m_wa), 32'(e.addr));
      chk({tag, " mem_wr_data"}, 32'(m_wd), 32'(e.data));
      c_wa[e.id*AB +: AB] = ~e.addr;
      c_wd[e.id*DB +: DB] = ~e.data;
    end else begin
      chk({tag, " mem_rd_addr"}, 32'(m_ra), 32'(e.addr));
      c_ra[e.id*AB +: AB] = ~e.addr;
    end
    for (int k = 0; k < lat; k++) begin
      if (e.wr) m_rr = 1'b1;  // read-side ready with no read pending
      tick();
      chk({tag, " hold_vld"}, 32'(e.wr ? m_wv : m_rv), 32'd1);
      chk({tag, " hold_addr"}, 32'(e.wr ? m_wa : m_ra), 32'(e.addr));
      chk({tag, " hold_rdy"}, 32'(c_rr | c_wr), 32'd0);
      chk({tag, " hold_terr"}, 32'(terr), 32'd0);
    end
    m_rr = 1'b0;
    if (e.wr) m_wr = 1'b1;
    else begin m_rr = 1'b1; m_rd = e.data; end
    tick();
    m_rr = 1'b0; m_wr = 1'b0; m_rd = 8'hEE;
    chk({tag, " mem_vld_clear"}, 32'(m_rv | m_wv), 32'd0);
    chk({tag, " rd_ready"}, 32'(c_rr), e.wr ? 32'd0 : (32'd1 << e.id));
    chk({tag, " wr_ready"}, 32'(c_wr), e.wr ? (32'd1 << e.id) : 32'd0);
    if (!e.wr) chk({tag, " rd_data"}, 32'(c_rd[e.id*DB +: DB]), 32'(e.data));
    chk({tag, " busy_relay"}, 32'(busy), 32'd1);
  endtask

  task automatic release_c(input string tag, input int id, input bit wr);
    if (wr) c_wv[id] = 1'b0;
    else c_rv[id] = 1'b0;
    tick();
    chk({tag, " rdy_cleared"}, 32'(c_rr | c_wr), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_rd_vld"}, 32'(m_rv), 32'd0);
    chk({tag, " mem_wr_vld"}, 32'(m_wv), 32'd0);
    chk({tag, " mem_rd_addr"}, 32'(m_ra), 32'd0);
    chk({tag, " mem_wr_addr"}, 32'(m_wa), 32'd0);
    chk({tag, " mem_wr_data"}, 32'(m_wd), 32'd0);
    chk({tag, " rd_ready"}, 32'(c_rr), 32'd0);
    chk({tag, " wr_ready"}, 32'(c_wr), 32'd0);
    chk({tag, " rd_data"}, 32'(c_rd), 32'd0);
    chk({tag, " grant_id"}, 32'(gid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " timeout_error"}, 32'(terr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    reset = 1'b0;
    c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
    m_rr = 1'b0; m_wr = 1'b0; m_rd = '0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b1;

    // Round robin from reset: 0,1,2,3 then 0 again.
    for (int i = 0; i < NC; i++) req_rd(i, 8'(8'h10 + i), 1'b1);
    serve("rr0", 1, w); release_c("rr0", 0, 1'b0);
    req_rd(0, 8'h30, 1'b1);
    serve("rr1", 2, w); release_c("rr1", 1, 1'b0);
    serve("rr2", 0, w); release_c("rr2", 2, 1'b0);
    serve("rr3", 1, w); release_c("rr3", 3, 1'b0);
    serve("rr0b", 1, w); release_c("rr0b", 0, 1'b0);

    // Single read: consumer 2, addr 0x15, memory answers 0xA7 after 3 cycles.
    req_rd(2, 8'h15, 1'b1);
    serve("single", 3, w);
    chk("single req_to_mem_cycles", 32'(w), 32'd1);
    chk("single data_A7", 32'(c_rd[2*DB +: DB]), 32'hA7);
    release_c("single", 2, 1'b0);

    // Read and write from the same consumer: read goes first.
    req_rd(1, 8'h20, 1'b1);
    req_wr(1, 8'h21, 8'h55);
    serve("prio_rd", 1, w); release_c("prio_rd", 1, 1'b0);
    serve("prio_wr", 2, w); release_c("prio_wr", 1, 1'b1);

    // Back-pressure: consumer 3 keeps valid for 5 cycles after ready.
    req_rd(3, 8'h33, 1'b1);
    serve("bp", 2, w);
    req_rd(0, 8'h44, 1'b1);
    req_rd(2, 8'h55, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp hold_rdy", 32'(c_rr), 32'h8);
      chk("bp hold_busy", 32'(busy), 32'd1);
      chk("bp hold_gid", 32'(gid), 32'd3);
      chk("bp no_mem_req", 32'(m_rv | m_wv), 32'd0);
    end
    release_c("bp", 3, 1'b0);
    serve("bp_next0", 1, w); release_c("bp_next0", 0, 1'b0);
    serve("bp_next2", 1, w); release_c("bp_next2", 2, 1'b0);

    // Idle with stray memory readies: nothing happens, last_grant keeps 2.
    m_rr = 1'b1; m_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle readys", 32'(c_rr | c_wr), 32'd0);
      chk("idle mem_vld", 32'(m_rv | m_wv), 32'd0);
    end
    m_rr = 1'b0; m_wr = 1'b0;
    req_rd(3, 8'h70, 1'b1);
    req_rd(0, 8'h71, 1'b0);
    c_ra[0 +: AB] = 8'h71;
    req_rd(0, 8'h71, 1'b1);
    serve("after_idle3", 1, w); release_c("after_idle3", 3, 1'b0);
    serve("after_idle0", 1, w); release_c("after_idle0", 0, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: timeout after 8 wait cycles.
    c_ra[1*AB +: AB] = 8'h40;
    c_rv[1] = 1'b1;
    n = 0;
    while (!m_rv && n < 20) begin tick(); n++; end
    chk("tmo grant", 32'(m_rv), 32'd1);
    chk("tmo gid", 32'(gid), 32'd1);
    n = 0;
    while (!terr && n < 40) begin tick(); n++; end
    chk("tmo cycles", 32'(n), 32'd8);
    chk("tmo rd_ready", 32'(c_rr), 32'h2);
    chk("tmo rd_data", 32'(c_rd[1*DB +: DB]), 32'd0);
    chk("tmo mem_vld", 32'(m_rv), 32'd0);
    tick();
    chk("tmo pulse_once", 32'(terr), 32'd0);
    chk("tmo rdy_held", 32'(c_rr), 32'h2);
    release_c("tmo", 1, 1'b0);
`else
    // Without the timeout the write simply waits for the memory.
    req_wr(2, 8'h77, 8'h3C);
    serve("longwait", 20, w);
    release_c("longwait", 2, 1'b1);
`endif

    // Reset in READ_WAIT drops the access; consumer 0 wins afterwards.
    req_rd(2, 8'h66, 1'b0);
    n = 0;
    while (!m_rv && n < 20) begin tick(); n++; end
    chk("rstmid in_wait", 32'(m_rv), 32'd1);
    reset = 1'b0;
    tick();
    chk_zero("rstmid");
    req_rd(0, 8'h60, 1'b1);
    req_rd(2, 8'h66, 1'b1);
    req_rd(3, 8'h68, 1'b1);
    reset = 1'b1;
    serve("rstmid_c0", 1, w); release_c("rstmid_c0", 0, 1'b0);
    serve("rstmid_c2", 1, w); release_c("rstmid_c2", 2, 1'b0);
    serve("rstmid_c3", 1, w); release_c("rstmid_c3", 3, 1'b0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU/fetcher requesters (at least 2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, memory-response wait limit (only used with MEM_ARB_TIMEOUT_EN).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port consumer_read_valid, input, NUM_CONSUMERS, per-consumer read request.
REQ-008 SHALL have port consumer_read_address, input, ADDR_BITS x NUM_CONSUMERS, read address.
REQ-009 SHALL have port consumer_read_ready, output, NUM_CONSUMERS, read data valid.
REQ-010 SHALL have port consumer_read_data, output, DATA_BITS x NUM_CONSUMERS, read data.
REQ-011 SHALL have port consumer_write_valid, input, NUM_CONSUMERS, per-consumer write request.
REQ-012 SHALL have ports consumer_write_address and consumer_write_data, inputs, ADDR_BITS x NUM_CONSUMERS and DATA_BITS x NUM_CONSUMERS, write address and data.
REQ-013 SHALL have port consumer_write_ready, output, NUM_CONSUMERS, write accepted.
REQ-014 SHALL have ports mem_read_valid (out, 1), mem_read_address (out, ADDR_BITS), mem_read_ready (in, 1) and mem_read_data (in, DATA_BITS), forming the single memory-channel read side.
REQ-015 SHALL have ports mem_write_valid (out, 1), mem_write_address (out, ADDR_BITS), mem_write_data (out, DATA_BITS) and mem_write_ready (in, 1), forming the single memory-channel write side.
REQ-016 SHALL have port grant_id, output, clog2(NUM_CONSUMERS), the consumer currently being served.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have port timeout_error, output, 1, a one-cycle timeout pulse.

Function
REQ-019 SHALL implement the states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY and WRITE_RELAY.
REQ-020 SHALL, in IDLE, search consumers round-robin, starting at last_grant+1 modulo NUM_CONSUMERS, for the first one with read_valid or write_valid whose ready is low.
REQ-021 SHALL, when a consumer has both read_valid and write_valid asserted, grant its read first.
REQ-022 SHALL, on a grant, on the same edge: update last_grant and grant_id; drive mem_read_valid/address or mem_write_valid/address/data from the granted consumer; and enter READ_WAIT or WRITE_WAIT (memory valid visible 1 cycle after request sampled).
REQ-023 SHALL, in READ_WAIT with mem_read_ready high, on that edge: clear mem_read_valid; load consumer_read_data[grant_id] with mem_read_data; set consumer_read_ready[grant_id]; and enter READ_RELAY.
REQ-024 SHALL, in WRITE_WAIT with mem_write_ready high, clear mem_write_valid, set consumer_write_ready[grant_id], and enter WRITE_RELAY.
REQ-025 SHALL, in READ_RELAY or WRITE_RELAY, once the granted consumer's corresponding valid is low, clear its ready and return to IDLE; the next grant is issued on a later edge at the earliest.
REQ-026 SHALL hold mem address/data stable while the mem valid is high, and SHALL ignore changes to consumer inputs after the grant.
REQ-027 SHALL keep all non-granted consumers' ready bits low, and SHALL assert at most one consumer ready bit at any time.
REQ-028 SHALL ignore mem_*_ready when the matching valid is low.
REQ-029 SHALL, with no requests, remain in IDLE and leave last_grant unchanged.

Reset
REQ-030 SHALL, while reset is low at a clock edge, clear all outputs (valids, readys, data, addresses, grant_id, busy, timeout_error) to 0, set state to IDLE, set last_grant to NUM_CONSUMERS-1 so consumer 0 has first priority, and clear the timeout counter.
REQ-031 SHALL apply reset asserted mid-transaction at once: any outstanding memory request is dropped, with no completion signalled to the consumer.

Configuration
REQ-032 SHALL, with macro MEM_ARB_TIMEOUT_EN defined, count cycles in READ_WAIT/WRITE_WAIT; when the count reaches TIMEOUT_CYCLES without mem ready, it SHALL clear the mem valid, assert the consumer ready (read data 0), pulse timeout_error for 1 cycle, and enter the matching RELAY state.
REQ-033 SHALL, without MEM_ARB_TIMEOUT_EN, wait indefinitely in the WAIT states, instantiate no counter, and tie timeout_error to 0.

Verification
REQ-034 SHALL cover a single read: consumer 2 reads addr 0x15, memory returns 0xA7 after 3 cycles -> mem_read_valid is high 1 cycle after the request, consumer_read_ready[2]=1 with data 0xA7, and ready clears 1 cycle after valid drops.
REQ-035 SHALL cover round-robin: all 4 consumers hold reads from reset -> grant order is 0,1,2,3,0.
REQ-036 SHALL cover read/write priority: consumer 1 asserts both a read of 0x20 and a write of 0x55 to 0x21 -> the read is served first, then the write, with mem_write_data=0x55.
REQ-037 SHALL cover reset mid-operation: reset goes low in READ_WAIT -> next edge all outputs are 0 and state is IDLE; after release, consumer 0 is granted first.
REQ-038 SHALL cover timeout with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory is never ready -> after 8 cycles timeout_error pulses once and consumer_read_data=0 with ready=1.
REQ-039 SHALL cover back-pressure: the consumer holds valid for 5 cycles after ready -> ready stays high, busy=1, and no other consumer is granted.
